// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding and default bus widths,
// common to the master and the matching slave.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready; flags the last permitted cycle
// so the master can abort instead of stalling forever.
module apb_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Wait-cycle counter: holds the number of completed wait cycles in ACCESS
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_r <= CNT_ZERO;
    end else if (clear) begin
      cnt_r <= CNT_ZERO;
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Current ACCESS cycle is the TIMEOUT-th one
  assign expired = (cnt_r == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// APB master: turns single commands into SETUP/ACCESS bus transfers and
// returns a one-cycle response pulse, aborting slaves that never assert pready.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_e        state_r;
  apb_state_e        next_s;
  logic              psel_r;
  logic              penable_r;
  logic              pwrite_r;
  logic [ADDR_W-1:0] paddr_r;
  logic [DATA_W-1:0] pwdata_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic              rsp_timeout_r;
  logic              expired_s;
  logic              complete_s;
  logic              abort_s;
  logic              accept_s;
  logic              timer_clear_s;
  logic              timer_enable_s;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) u_wait_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (timer_clear_s),
    .enable  (timer_enable_s),
    .expired (expired_s)
  );

  // Handshake and termination decodes; cmd_ready is forced low while in reset
  always_comb begin
    cmd_ready      = resetn && (state_r == IDLE);
    accept_s       = cmd_valid && cmd_ready;
    complete_s     = (state_r == ACCESS) && pready;
    abort_s        = (state_r == ACCESS) && !pready && expired_s;
    timer_clear_s  = (state_r != ACCESS);
    timer_enable_s = (state_r == ACCESS) && !pready;
  end

  // Next-state logic for the transfer sequencer
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_s = SETUP;
        end else begin
          next_s = IDLE;
        end
      end
      SETUP: begin
        next_s = ACCESS;
      end
      ACCESS: begin
        if (complete_s || abort_s) begin
          next_s = IDLE;
        end else begin
          next_s = ACCESS;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State register plus registered bus controls derived from the next state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= IDLE;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      psel_r    <= (next_s != IDLE);
      penable_r <= (next_s == ACCESS);
    end
  end

  // Address/data capture; held unchanged from acceptance until the next command
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pwrite_r <= 1'b0;
      paddr_r  <= {ADDR_W{1'b0}};
      pwdata_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      pwrite_r <= cmd_write;
      paddr_r  <= cmd_addr;
      pwdata_r <= cmd_wdata;
    end else begin
      pwrite_r <= pwrite_r;
      paddr_r  <= paddr_r;
      pwdata_r <= pwdata_r;
    end
  end

  // Response pulse; slave outputs are only trusted in the pready cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_valid_r   <= 1'b0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
    end else if (complete_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_err_r     <= pslverr;
      rsp_timeout_r <= 1'b0;
      rsp_rdata_r   <= pwrite_r ? {DATA_W{1'b0}} : prdata;
    end else if (abort_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_err_r     <= 1'b1;
      rsp_timeout_r <= 1'b1;
      rsp_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      rsp_valid_r   <= 1'b0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
    end
  end

  assign psel        = psel_r;
  assign penable     = penable_r;
  assign pwrite      = pwrite_r;
  assign paddr       = paddr_r;
  assign pwdata      = pwdata_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a scripted slave drives pready/pslverr/prdata,
// and a scoreboard queue pairs every issued command with its response pulse.
`timescale 1ns/1ps
module tb_apb_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  int   accept_cyc = 0;
  int   t0;

  apb_master #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .prdata      (prdata)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index used to measure acceptance spacing
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding command
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
      end
    end
  end

  // One transfer, starting at #1 into an IDLE cycle; ends at #1 into the response cycle
  task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] wd,
                      input int waits, input logic slverr, input logic [31:0] rd,
                      input logic hold);
    rsp_t e;
    logic tmo;
    tmo     = (waits >= TO);
    e.rdata = (tmo || w) ? 32'd0 : rd;
    e.err   = tmo ? 1'b1 : slverr;
    e.tmo   = tmo;
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = wd;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    accept_cyc = cyc;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    chk("setup_psel", 32'(psel), 32'd1);
    chk("setup_penable", 32'(penable), 32'd0);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("setup_paddr", 32'(paddr), 32'(a));
    chk("setup_pwrite", 32'(pwrite), 32'(w));
    chk("setup_pwdata", pwdata, wd);
    @(posedge clk); #1;
    for (int i = 0; i < TO; i++) begin
      chk("access_psel", 32'(psel), 32'd1);
      chk("access_penable", 32'(penable), 32'd1);
      chk("access_paddr", 32'(paddr), 32'(a));
      chk("access_pwrite", 32'(pwrite), 32'(w));
      chk("access_pwdata", pwdata, wd);
      pready  = (i == waits);
      pslverr = (i == waits) ? slverr : ~slverr;
      prdata  = (i == waits) ? rd : ~rd;
      @(posedge clk); #1;
      if (i == waits || i == TO - 1) break;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'h0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("done_psel", 32'(psel), 32'd0);
    chk("done_penable", 32'(penable), 32'd0);
    chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle_paddr_hold", 32'(paddr), 32'(a));
  endtask

  initial begin
    resetn    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 5'h1F;
    cmd_wdata = 32'h1234_5678;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 32'h0;

    // Reset with a command pending: it must be dropped
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    resetn    = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_psel", 32'(psel), 32'd0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write, then read back with three wait cycles
    xfer(1'b1, 5'd5, 32'hDEAD_BEEF, 0, 1'b0, 32'h1111_2222, 1'b0);
    @(posedge clk); #1;
    chk("idle_rsp_valid_low", 32'(rsp_valid), 32'd0);
    xfer(1'b0, 5'd5, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Slave error on completion; error asserted during waits is ignored
    xfer(1'b0, 5'd31, 32'h0, 0, 1'b1, 32'hA5A5_0001, 1'b0);
    xfer(1'b0, 5'd31, 32'h0, 2, 1'b0, 32'h0BAD_F00D, 1'b0);

    // Timeout boundary: never ready, then ready in the last allowed cycle
    xfer(1'b0, 5'd7, 32'h0, 40, 1'b0, 32'h7777_0007, 1'b0);
    xfer(1'b0, 5'd9, 32'h0, TO - 1, 1'b0, 32'hCAFE_0016, 1'b0);
    xfer(1'b1, 5'd9, 32'h5555_AAAA, TO - 1, 1'b1, 32'h0, 1'b0);

    // Back-to-back commands with cmd_valid held high
    xfer(1'b1, 5'd1, 32'h0101_0101, 0, 1'b0, 32'h0, 1'b1);
    t0 = accept_cyc;
    xfer(1'b0, 5'd2, 32'h0202_0202, 0, 1'b0, 32'h2020_2020, 1'b1);
    chk("b2b_spacing_1", 32'(accept_cyc - t0), 32'd3);
    t0 = accept_cyc;
    xfer(1'b1, 5'd3, 32'h0303_0303, 0, 1'b1, 32'h0, 1'b0);
    chk("b2b_spacing_2", 32'(accept_cyc - t0), 32'd3);
    @(posedge clk); #1;
    chk("b2b_idle_psel", 32'(psel), 32'd0);

    // Reset in the middle of an ACCESS phase: no response may follow
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'd12;
    cmd_wdata = 32'h0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_access_penable", 32'(penable), 32'd1);
    resetn    = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_penable", 32'(penable), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_paddr", 32'(paddr), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_rsp_valid_2", 32'(rsp_valid), 32'd0);
    resetn    = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rel_psel", 32'(psel), 32'd0);
    chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);

    // Normal operation resumes after the aborted transfer
    xfer(1'b0, 5'd20, 32'h0, 1, 1'b0, 32'h2020_5A5A, 1'b0);
    @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
